// File: rtl/psram_req_queue.sv
// psram_req_queue: request FIFO and single-outstanding sequencer in front of
// PsramController. Issues one 1-cycle read/write strobe per queued request,
// waits for the controller's busy to drop (or times out), returns an in-order
// completion and keeps 1x/2x latency and timeout statistics.
module psram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic        rsp_err,
  output logic [15:0] rsp_rdata,
  output logic [7:0]  rsp_byte,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte_write,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  input  logic        stat_clr,
  output logic [23:0] wr_1x,
  output logic [23:0] wr_2x,
  output logic [23:0] rd_1x,
  output logic [23:0] rd_2x,
  output logic        timeout_seen
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 40;
  localparam int CW = $clog2(10 + 2 * LATENCY + 1) + 1;
  localparam logic [CW-1:0] WR_TIMEOUT = CW'(5 + 2 * LATENCY);
  localparam logic [CW-1:0] RD_TIMEOUT = CW'(10 + 2 * LATENCY);
  localparam logic [CW-1:0] WR_1X_MAX  = CW'(4 + LATENCY);
  localparam logic [CW-1:0] RD_1X_MAX  = CW'(10 + LATENCY);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_reg;
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [AW:0]   count_reg;
  logic [CW-1:0] cnt_reg;
  logic          op_we_reg;
  logic          timeout_seen_reg;

  logic          push;
  logic          pop;
  logic          done;
  logic          timeout;
  logic [EW-1:0] head_entry;
  logic [CW-1:0] timeout_lim;
  logic [3:0]    stat_inc;
  logic [4*24-1:0] stat_bus;

  assign req_ready   = (count_reg != (AW+1)'(DEPTH));
  assign push        = req_valid && req_ready;
  assign pop         = (state_reg == ST_IDLE) && (count_reg != '0) && !mem_busy;
  assign head_entry  = fifo_mem[head_reg];
  assign timeout_lim = op_we_reg ? WR_TIMEOUT : RD_TIMEOUT;
  // busy is ignored for the first WAIT cycle so the controller has time to raise it
  assign done        = (state_reg == ST_WAIT) && (cnt_reg >= CW'(2)) && !mem_busy;
  assign timeout     = (state_reg == ST_WAIT) && !done && mem_busy && (cnt_reg == timeout_lim);

  // FIFO storage write: {we, byte, addr, wdata}
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_reg] <= {req_we, req_byte, req_addr, req_wdata};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + AW'(1);
      if (pop)  head_reg <= head_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sequencer: issue strobe, wait for completion or timeout, register response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      op_we_reg      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
      rsp_valid      <= 1'b0;
      rsp_we         <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
      rsp_byte       <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            op_we_reg      <= head_entry[39];
            mem_byte_write <= head_entry[38];
            mem_addr       <= head_entry[37:16];
            mem_din        <= head_entry[15:0];
            mem_write      <= head_entry[39];
            mem_read       <= !head_entry[39];
            cnt_reg        <= CW'(1);
            state_reg      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_we    <= op_we_reg;
            rsp_err   <= 1'b0;
            rsp_rdata <= op_we_reg ? 16'h0000 : mem_dout;
            rsp_byte  <= op_we_reg ? 8'h00 : (mem_addr[0] ? mem_dout[15:8] : mem_dout[7:0]);
            state_reg <= ST_IDLE;
          end else if (timeout) begin
            rsp_valid <= 1'b1;
            rsp_we    <= op_we_reg;
            rsp_err   <= 1'b1;
            rsp_rdata <= 16'h0000;
            rsp_byte  <= 8'h00;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Latency classification of a successful completion: 0=wr_1x 1=wr_2x 2=rd_1x 3=rd_2x
  always_comb begin
    stat_inc = '0;
    if (done) begin
      if (op_we_reg) begin
        if (cnt_reg > WR_1X_MAX) stat_inc[1] = 1'b1;
        else                     stat_inc[0] = 1'b1;
      end else begin
        if (cnt_reg > RD_1X_MAX) stat_inc[3] = 1'b1;
        else                     stat_inc[2] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      logic [23:0] stat_reg;
      // Saturating statistics counter; clear takes priority over increment
      always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
          stat_reg <= '0;
        end else if (stat_inc[gi] && (stat_reg != 24'hFFFFFF)) begin
          stat_reg <= stat_reg + 24'd1;
        end
      end
      assign stat_bus[gi*24 +: 24] = stat_reg;
    end
  endgenerate

  // Sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      timeout_seen_reg <= 1'b0;
    end else if (timeout) begin
      timeout_seen_reg <= 1'b1;
    end
  end

  assign wr_1x        = stat_bus[0*24 +: 24];
  assign wr_2x        = stat_bus[1*24 +: 24];
  assign rd_1x        = stat_bus[2*24 +: 24];
  assign rd_2x        = stat_bus[3*24 +: 24];
  assign timeout_seen = timeout_seen_reg;

endmodule

// File: tb/tb_psram_req_queue.sv
// Testbench for psram_req_queue: a transaction-level model (request queue,
// one outstanding op with a busy duration chosen by the bench) predicts every
// output each cycle; directed scenarios add literal expectations.
`timescale 1ns/1ps
module tb_psram_req_queue;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
  localparam int WR_TO   = 5 + 2 * LATENCY;
  localparam int RD_TO   = 10 + 2 * LATENCY;

  typedef struct packed {
    logic        we;
    logic        bw;
    logic [21:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_we = 1'b0, req_byte = 1'b0;
  logic [21:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid, rsp_we, rsp_err;
  logic [15:0] rsp_rdata;
  logic [7:0]  rsp_byte;
  logic        mem_read, mem_write, mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_busy = 1'b0;
  logic        stat_clr = 1'b0;
  logic [23:0] wr_1x, wr_2x, rd_1x, rd_2x;
  logic        timeout_seen;

  always #5 clk = ~clk;

  psram_req_queue #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .rsp_byte(rsp_byte),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_write(mem_byte_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy),
    .stat_clr(stat_clr),
    .wr_1x(wr_1x), .wr_2x(wr_2x), .rd_1x(rd_1x), .rd_2x(rd_2x),
    .timeout_seen(timeout_seen)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  req_t        q[$];
  logic        m_active = 0;
  req_t        m_op;
  int          m_rsp_cyc = 0;
  logic        m_err = 0;
  int          m_k = 0;
  logic [15:0] m_dout = '0;
  int          busy_left = 0;
  logic        e_rd = 0, e_wr = 0, e_rsp = 0, e_rsp_we = 0, e_rsp_err = 0, e_bw = 0, e_tos = 0;
  logic [15:0] e_rdata = '0, e_din = '0;
  logic [7:0]  e_byte = '0;
  logic [21:0] e_addr = '0;
  int          e_stat[4] = '{0, 0, 0, 0};

  // stimulus knobs
  int   force_b = -1;
  int   force_dout = -1;
  int   idle_busy_pct = 10;
  logic force_idle_busy = 0;

  // observations for directed literal checks
  int          obs_rsp = 0, obs_err = 0, obs_wr = 0, obs_rd = 0, obs_acc = 0;
  int          last_rsp_cyc = 0, last_strobe_cyc = 0;
  logic [7:0]  last_rsp_byte = '0;
  logic [15:0] last_rsp_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; busy_left = 0;
    e_rd = 0; e_wr = 0; e_rsp = 0; e_addr = '0; e_din = '0; e_bw = 0;
    e_stat = '{0, 0, 0, 0}; e_tos = 0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model to the next cycle
  task automatic step(input logic rst, input logic v, input req_t r, input logic clr);
    logic busy, do_pop, do_push, do_fin;
    int b, t, idx;
    logic [15:0] rd;
    chk("req_ready", req_ready, (q.size() < DEPTH));
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_din", mem_din, e_din);
    chk("mem_byte_write", mem_byte_write, e_bw);
    chk("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp) begin
      chk("rsp_we", rsp_we, e_rsp_we);
      chk("rsp_err", rsp_err, e_rsp_err);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_byte", rsp_byte, e_byte);
    end
    chk("wr_1x", wr_1x, e_stat[0]);
    chk("wr_2x", wr_2x, e_stat[1]);
    chk("rd_1x", rd_1x, e_stat[2]);
    chk("rd_2x", rd_2x, e_stat[3]);
    chk("timeout_seen", timeout_seen, e_tos);

    if (rsp_valid === 1'b1) begin
      obs_rsp++;
      if (rsp_err === 1'b1) obs_err++;
      last_rsp_byte = rsp_byte; last_rsp_rdata = rsp_rdata; last_rsp_cyc = cyc;
    end
    if (mem_write === 1'b1) begin obs_wr++; last_strobe_cyc = cyc; end
    if (mem_read === 1'b1) begin obs_rd++; last_strobe_cyc = cyc; end
    if (v && (req_ready === 1'b1)) obs_acc++;

    if (busy_left > 0) begin
      busy = 1; busy_left--;
    end else if (m_active) begin
      busy = 0;
    end else begin
      busy = force_idle_busy || ($urandom_range(0, 99) < idle_busy_pct);
    end

    reset = rst; req_valid = v; req_we = r.we; req_byte = r.bw;
    req_addr = r.addr; req_wdata = r.wdata;
    mem_busy = busy; mem_dout = m_dout; stat_clr = clr;

    if (rst) begin
      model_reset();
    end else begin
      do_pop  = !m_active && (q.size() > 0) && !busy;
      do_push = v && (q.size() < DEPTH);
      do_fin  = m_active && (cyc + 1 == m_rsp_cyc);
      e_rd = 0; e_wr = 0; e_rsp = 0;
      if (do_fin) begin
        e_rsp = 1; e_rsp_we = m_op.we; e_rsp_err = m_err;
        rd = (m_err || m_op.we) ? 16'h0000 : m_dout;
        e_rdata = rd;
        e_byte = m_op.addr[0] ? rd[15:8] : rd[7:0];
        m_active = 0;
        if (m_err) begin
          e_tos = 1;
        end else begin
          if (m_op.we) idx = (m_k > 4 + LATENCY) ? 1 : 0;
          else         idx = (m_k > 10 + LATENCY) ? 3 : 2;
          if (e_stat[idx] < 24'hFFFFFF) e_stat[idx]++;
        end
      end
      if (clr) begin
        e_stat = '{0, 0, 0, 0}; e_tos = 0;
      end
      if (do_pop) begin
        m_op = q.pop_front();
        e_addr = m_op.addr; e_din = m_op.wdata; e_bw = m_op.bw;
        e_rd = !m_op.we; e_wr = m_op.we;
        b = (force_b >= 0) ? force_b : int'($urandom_range(0, 20));
        t = m_op.we ? WR_TO : RD_TO;
        busy_left = b;
        m_active = 1;
        if (b >= t) begin m_err = 1; m_k = t; end
        else begin m_err = 0; m_k = (b + 1 < 2) ? 2 : b + 1; end
        m_rsp_cyc = cyc + 1 + m_k;
        m_dout = (force_dout >= 0) ? 16'(force_dout) : 16'($urandom);
      end
      if (do_push) q.push_back(r);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_idle(input int n);
    req_t rz;
    rz = '0;
    for (int i = 0; i < n; i++) step(0, 0, rz, 0);
  endtask

  initial begin
    req_t r, rz;
    int base_wr, base_rsp, base_acc, base_err;
    rz = '0;
    repeat (3) @(negedge clk);
    model_reset();

    // Test 1: busy high after reset; the queued write waits, then exactly one strobe
    step(1, 0, rz, 0);
    idle_busy_pct = 0; force_idle_busy = 1; force_b = 2;
    base_wr = obs_wr; base_rsp = obs_rsp;
    r = '{we: 1'b1, bw: 1'b0, addr: 22'h000010, wdata: 16'hBEEF};
    step(0, 1, r, 0);
    run_idle(49);
    chk("t1_no_write_while_busy", obs_wr - base_wr, 0);
    force_idle_busy = 0;
    run_idle(20);
    chk("t1_one_write", obs_wr - base_wr, 1);
    chk("t1_one_rsp", obs_rsp - base_rsp, 1);

    // Test 2: write 0x1234 @1 then read it back
    step(1, 0, rz, 0);
    base_rsp = obs_rsp;
    force_b = 6;
    r = '{we: 1'b1, bw: 1'b0, addr: 22'h000001, wdata: 16'h1234};
    step(0, 1, r, 0);
    run_idle(20);
    force_b = 12; force_dout = 16'h1234;
    r = '{we: 1'b0, bw: 1'b0, addr: 22'h000001, wdata: 16'h0000};
    step(0, 1, r, 0);
    run_idle(30);
    chk("t2_rsp_count", obs_rsp - base_rsp, 2);
    chk("t2_rsp_byte", last_rsp_byte, 8'h12);
    chk("t2_rsp_rdata", last_rsp_rdata, 16'h1234);
    chk("t2_wr_1x", wr_1x, 1);
    chk("t2_rd_1x", rd_1x, 1);
    force_dout = -1;

    // Test 3: read with busy 15 cycles lands in the 2x bucket
    step(1, 0, rz, 0);
    force_b = 15;
    r = '{we: 1'b0, bw: 1'b0, addr: 22'h000100, wdata: 16'h0000};
    step(0, 1, r, 0);
    run_idle(30);
    chk("t3_rd_2x", rd_2x, 1);
    chk("t3_rd_1x", rd_1x, 0);

    // Test 4: busy stuck high on a write times out at cnt=11; stat_clr clears
    step(1, 0, rz, 0);
    force_b = 40; base_err = obs_err;
    r = '{we: 1'b1, bw: 1'b1, addr: 22'h000200, wdata: 16'h5A5A};
    step(0, 1, r, 0);
    run_idle(30);
    chk("t4_err_rsp", obs_err - base_err, 1);
    chk("t4_timeout_seen", timeout_seen, 1);
    chk("t4_timeout_delay", last_rsp_cyc - last_strobe_cyc, 11);
    chk("t4_wr_1x", wr_1x, 0);
    step(0, 0, rz, 1);
    chk("t4_clr_timeout_seen", timeout_seen, 0);
    run_idle(30);

    // Test 5: six back-to-back pushes into a depth-4 queue
    step(1, 0, rz, 0);
    force_b = 10; base_acc = obs_acc; base_rsp = obs_rsp;
    for (int i = 0; i < 6; i++) begin
      r = '{we: i[0], bw: 1'b0, addr: 22'(i * 3 + 1), wdata: 16'(16'hA000 + i)};
      step(0, 1, r, 0);
    end
    chk("t5_accepted", obs_acc - base_acc, 5);
    run_idle(100);
    chk("t5_rsp_count", obs_rsp - base_rsp, 5);

    // Test 6: reset during WAIT abandons the op
    step(1, 0, rz, 0);
    base_rsp = obs_rsp;
    r = '{we: 1'b1, bw: 1'b0, addr: 22'h000300, wdata: 16'h1111};
    step(0, 1, r, 0);
    run_idle(5);
    step(1, 0, rz, 0);
    chk("t6_ready_after_reset", req_ready, 1);
    run_idle(30);
    chk("t6_no_rsp", obs_rsp - base_rsp, 0);

    // Randomized traffic
    force_b = -1; force_dout = -1; idle_busy_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      r.we    = 1'($urandom);
      r.bw    = 1'($urandom);
      r.addr  = 22'($urandom);
      r.wdata = 16'($urandom);
      step(($urandom_range(0, 999) < 3), ($urandom_range(0, 99) < 40), r,
           ($urandom_range(0, 99) < 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
